// File: rtl/plic_irq_gateway.sv
// ---------------------------------------------------------------------------
// plic_irq_gateway
//
// Per-source interrupt gateway sitting in front of the PLIC pending (IP) bit.
// It synchronises the raw device line, applies level or rising-edge
// semantics, and offers at most one request at a time through a valid/ready
// handshake. Once a request is taken it blocks the source until the core
// signals completion. In edge mode, edges seen while a request is
// outstanding are counted, up to MAX_PEND, so they are not lost.
//
// Ports:
//   pclk        clock
//   preset      synchronous active-high reset
//   irq_i       raw device interrupt line (asynchronous to pclk)
//   mode_i      0 = level-triggered, 1 = rising-edge-triggered
//   ready_i     core can accept a request (~IP of this source)
//   comp_i      single-cycle completion strobe for this source
//   valid_o     request to set IP
//   busy_o      request accepted, completion not yet seen
//   pend_cnt_o  number of queued edges (edge mode only, else 0)
//   ovf_o       one-cycle pulse when an edge is dropped at saturation
// ---------------------------------------------------------------------------
module plic_irq_gateway #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_PEND    = 7,
  parameter int CNT_WIDTH   = $clog2(MAX_PEND + 1)
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 irq_i,
  input  logic                 mode_i,
  input  logic                 ready_i,
  input  logic                 comp_i,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] pend_cnt_o,
  output logic                 ovf_o
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQ      = 2'd1;
  localparam logic [1:0] ST_INFLIGHT = 2'd2;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_PEND);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sDly;
  logic                   r_mode;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_ovf;
  logic [1:0]             r_state;
  logic                   r_valid;
  logic                   r_busy;

  logic       w_s;
  logic       w_edge;
  logic       w_modeChg;
  logic       w_hs;
  logic       w_reqCond;
  logic [1:0] w_nextState;

  // Synchroniser chain for the asynchronous device line, followed by one
  // history flop. The history flop serves both as the edge detector's
  // delayed copy and as the level seen by the FSM, which gives level and
  // edge modes the same request latency (the edge only reaches the FSM
  // after it has been counted).
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_sync <= '0;
      r_sDly <= 1'b0;
    end else begin
      r_sync[0] <= irq_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_sDly <= w_s;
    end
  end

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_edge    = w_s & ~r_sDly;
  assign w_hs      = r_valid & ready_i;
  assign w_modeChg = (mode_i != r_mode);

  // Registered copy of the trigger mode; every other block works from it.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_mode <= 1'b0;
    end else begin
      r_mode <= mode_i;
    end
  end

  // Pending-edge counter. An edge and a handshake in the same cycle cancel
  // out, even at saturation; a lone edge at saturation is dropped and
  // flagged. The count is meaningless in level mode and is discarded
  // whenever the mode flips.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      if (!r_mode || w_modeChg) begin
        r_cnt <= '0;
      end else if (w_edge && !w_hs) begin
        if (r_cnt == MAX_CNT) begin
          r_ovf <= 1'b1;
        end else begin
          r_cnt <= r_cnt + ONE_CNT;
        end
      end else if (!w_edge && w_hs && (r_cnt != '0)) begin
        r_cnt <= r_cnt - ONE_CNT;
      end
    end
  end

  // Request condition while idle: the delayed level in level mode, any
  // queued edge in edge mode.
  assign w_reqCond = r_mode ? (r_cnt != '0) : r_sDly;

  // Gateway FSM. A level request may be withdrawn if the line drops before
  // the core takes it; an edge request stays up until accepted. comp_i only
  // matters while a request is in flight.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_reqCond) begin
          w_nextState = ST_REQ;
        end
      end
      ST_REQ: begin
        if (w_hs) begin
          w_nextState = ST_INFLIGHT;
        end else if (!r_mode && !r_sDly) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_INFLIGHT: begin
        if (comp_i) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State register plus registered decodes, so valid_o and busy_o come
  // straight from flops.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_valid <= (w_nextState == ST_REQ);
      r_busy  <= (w_nextState == ST_INFLIGHT);
    end
  end

  assign valid_o    = r_valid;
  assign busy_o     = r_busy;
  assign pend_cnt_o = r_cnt;
  assign ovf_o      = r_ovf;

endmodule

// File: tb/tb_plic_irq_gateway.sv
// ---------------------------------------------------------------------------
// tb_plic_irq_gateway
//
// Self-checking bench for plic_irq_gateway with default parameters
// (SYNC_STAGES = 2, MAX_PEND = 7). Each stimulus step drives the inputs,
// waits for one pclk edge and queues the outputs expected after that edge.
// An independent monitor pops one expectation per cycle on the falling edge
// and compares it with what the DUT presents.
// ---------------------------------------------------------------------------
module tb_plic_irq_gateway;

  logic       pclk;
  logic       preset;
  logic       irq_i;
  logic       mode_i;
  logic       ready_i;
  logic       comp_i;
  logic       valid_o;
  logic       busy_o;
  logic [2:0] pend_cnt_o;
  logic       ovf_o;

  typedef struct {
    logic       vld;
    logic       bsy;
    logic [2:0] cnt;
    logic       ovf;
    string      name;
  } expT;

  expT expQ[$];
  int  testsRun;
  int  testsFailed;

  plic_irq_gateway #(
    .SYNC_STAGES(2),
    .MAX_PEND(7)
  ) dut (
    .pclk(pclk),
    .preset(preset),
    .irq_i(irq_i),
    .mode_i(mode_i),
    .ready_i(ready_i),
    .comp_i(comp_i),
    .valid_o(valid_o),
    .busy_o(busy_o),
    .pend_cnt_o(pend_cnt_o),
    .ovf_o(ovf_o)
  );

  // 10 ns clock; rising edges at 5, 15, 25, ...
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // Inputs are set by the caller beforehand; this waits for the edge that
  // samples them and records what the outputs must be after that edge.
  task automatic applyStimulus(input logic eVld, input logic eBsy,
                               input logic [2:0] eCnt, input logic eOvf,
                               input string name);
    expT e;
    @(posedge pclk);
    #1;
    e.vld  = eVld;
    e.bsy  = eBsy;
    e.cnt  = eCnt;
    e.ovf  = eOvf;
    e.name = name;
    expQ.push_back(e);
  endtask

  // Compares one expectation against the current DUT outputs.
  task automatic checkOutput(input expT e);
    testsRun++;
    if (valid_o !== e.vld) begin
      testsFailed++;
      $display("[TB] FAIL %s valid_o got %0b want %0b", e.name, valid_o, e.vld);
    end
    testsRun++;
    if (busy_o !== e.bsy) begin
      testsFailed++;
      $display("[TB] FAIL %s busy_o got %0b want %0b", e.name, busy_o, e.bsy);
    end
    testsRun++;
    if (pend_cnt_o !== e.cnt) begin
      testsFailed++;
      $display("[TB] FAIL %s pend_cnt_o got %0d want %0d", e.name, pend_cnt_o, e.cnt);
    end
    testsRun++;
    if (ovf_o !== e.ovf) begin
      testsFailed++;
      $display("[TB] FAIL %s ovf_o got %0b want %0b", e.name, ovf_o, e.ovf);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge pclk);
      if (expQ.size() != 0) begin
        checkOutput(expQ.pop_front());
      end
    end
  end

  initial begin
    int qCnt[14];
    int zCnt[13];
    int nEdges;
    int expCnt;

    testsRun    = 0;
    testsFailed = 0;
    preset  = 1'b1;
    irq_i   = 1'b0;
    mode_i  = 1'b0;
    ready_i = 1'b0;
    comp_i  = 1'b0;

    // Reset state
    applyStimulus(0, 0, 3'd0, 0, "reset0");
    applyStimulus(0, 0, 3'd0, 0, "reset1");
    preset = 1'b0;
    applyStimulus(0, 0, 3'd0, 0, "idle0");
    applyStimulus(0, 0, 3'd0, 0, "idle1");

    // Level basic: request three edges after irq_i is first sampled high
    irq_i = 1'b1;
    applyStimulus(0, 0, 3'd0, 0, "lvl_e0");
    applyStimulus(0, 0, 3'd0, 0, "lvl_e1");
    applyStimulus(0, 0, 3'd0, 0, "lvl_e2");
    applyStimulus(1, 0, 3'd0, 0, "lvl_e3_valid");
    ready_i = 1'b1;
    applyStimulus(0, 1, 3'd0, 0, "lvl_accept");
    ready_i = 1'b0;
    applyStimulus(0, 1, 3'd0, 0, "lvl_inflight");
    comp_i = 1'b1;
    applyStimulus(0, 0, 3'd0, 0, "lvl_comp_idle");
    comp_i = 1'b0;
    applyStimulus(1, 0, 3'd0, 0, "lvl_rearm");
    irq_i   = 1'b0;
    ready_i = 1'b1;
    applyStimulus(0, 1, 3'd0, 0, "lvl_accept2");
    ready_i = 1'b0;
    applyStimulus(0, 1, 3'd0, 0, "lvl_inflight2a");
    applyStimulus(0, 1, 3'd0, 0, "lvl_inflight2b");
    comp_i = 1'b1;
    applyStimulus(0, 0, 3'd0, 0, "lvl_comp2");
    comp_i = 1'b0;
    applyStimulus(0, 0, 3'd0, 0, "lvl_no_rearm");
    applyStimulus(0, 0, 3'd0, 0, "lvl_quiet");
    comp_i = 1'b1;
    applyStimulus(0, 0, 3'd0, 0, "comp_in_idle");
    comp_i = 1'b0;
    applyStimulus(0, 0, 3'd0, 0, "comp_in_idle_after");

    // Level retract: irq_i high for four samples, then low
    irq_i = 1'b1;
    applyStimulus(0, 0, 3'd0, 0, "ret_0");
    applyStimulus(0, 0, 3'd0, 0, "ret_1");
    applyStimulus(0, 0, 3'd0, 0, "ret_2");
    applyStimulus(1, 0, 3'd0, 0, "ret_valid");
    irq_i = 1'b0;
    applyStimulus(1, 0, 3'd0, 0, "ret_hold0");
    comp_i = 1'b1;
    applyStimulus(1, 0, 3'd0, 0, "ret_comp_in_req");
    comp_i = 1'b0;
    applyStimulus(1, 0, 3'd0, 0, "ret_hold2");
    applyStimulus(0, 0, 3'd0, 0, "ret_drop");
    applyStimulus(0, 0, 3'd0, 0, "ret_idle");

    // Edge queueing: switch to edge mode, three clean edges, ready low
    mode_i = 1'b1;
    applyStimulus(0, 0, 3'd0, 0, "q_mode");
    applyStimulus(0, 0, 3'd0, 0, "q_idle");
    qCnt = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3};
    for (int k = 2; k < 14; k++) begin
      irq_i = (((k - 2) % 4) < 2);
      applyStimulus((k >= 5), 0, 3'(qCnt[k]), 0, $sformatf("q_edge_%0d", k));
    end
    irq_i = 1'b0;
    ready_i = 1'b1;
    applyStimulus(0, 1, 3'd2, 0, "q_take1");
    ready_i = 1'b0;
    applyStimulus(0, 1, 3'd2, 0, "q_busy1");
    comp_i = 1'b1;
    applyStimulus(0, 0, 3'd2, 0, "q_comp1");
    comp_i = 1'b0;
    applyStimulus(1, 0, 3'd2, 0, "q_rearm1");
    ready_i = 1'b1;
    applyStimulus(0, 1, 3'd1, 0, "q_take2");
    ready_i = 1'b0;
    comp_i  = 1'b1;
    applyStimulus(0, 0, 3'd1, 0, "q_comp2");
    comp_i = 1'b0;
    applyStimulus(1, 0, 3'd1, 0, "q_rearm2");
    ready_i = 1'b1;
    applyStimulus(0, 1, 3'd0, 0, "q_take3");
    ready_i = 1'b0;
    comp_i  = 1'b1;
    applyStimulus(0, 0, 3'd0, 0, "q_comp3");
    comp_i = 1'b0;
    applyStimulus(0, 0, 3'd0, 0, "q_empty0");
    applyStimulus(0, 0, 3'd0, 0, "q_empty1");

    // Saturation: nine edges with ready low; edges 8 and 9 are dropped
    for (int s = 0; s < 36; s++) begin
      irq_i  = ((s % 4) < 2);
      nEdges = (s >= 2) ? ((s - 2) / 4 + 1) : 0;
      expCnt = (nEdges > 7) ? 7 : nEdges;
      applyStimulus((s >= 3), 0, 3'(expCnt), ((s == 30) || (s == 34)),
                    $sformatf("sat_%0d", s));
    end
    irq_i = 1'b0;
    applyStimulus(1, 0, 3'd7, 0, "sat_hold0");
    applyStimulus(1, 0, 3'd7, 0, "sat_hold1");

    // Edge on the handshake cycle at saturation: count unchanged, no overflow
    irq_i = 1'b1;
    applyStimulus(1, 0, 3'd7, 0, "sim_0");
    applyStimulus(1, 0, 3'd7, 0, "sim_1");
    irq_i   = 1'b0;
    ready_i = 1'b1;
    applyStimulus(0, 1, 3'd7, 0, "sim_edge_and_hs");
    ready_i = 1'b0;
    applyStimulus(0, 1, 3'd7, 0, "sim_busy");
    comp_i = 1'b1;
    applyStimulus(0, 0, 3'd7, 0, "sim_comp");
    applyStimulus(1, 0, 3'd7, 0, "sim_rearm_comp_ignored");
    comp_i  = 1'b0;
    ready_i = 1'b1;
    applyStimulus(0, 1, 3'd6, 0, "drain_take6");
    ready_i = 1'b0;
    comp_i  = 1'b1;
    applyStimulus(0, 0, 3'd6, 0, "drain_comp6");
    comp_i = 1'b0;
    applyStimulus(1, 0, 3'd6, 0, "drain_rearm6");
    ready_i = 1'b1;
    applyStimulus(0, 1, 3'd5, 0, "drain_take5");
    ready_i = 1'b0;
    comp_i  = 1'b1;
    applyStimulus(0, 0, 3'd5, 0, "drain_comp5");
    comp_i = 1'b0;
    applyStimulus(1, 0, 3'd5, 0, "drain_rearm5");
    ready_i = 1'b1;
    applyStimulus(0, 1, 3'd4, 0, "drain_take4");
    ready_i = 1'b0;
    applyStimulus(0, 1, 3'd4, 0, "drain_busy4");

    // Mode toggle with four queued edges clears the count, keeps the state
    mode_i = 1'b0;
    applyStimulus(0, 1, 3'd0, 0, "mode_toggle_clear");
    applyStimulus(0, 1, 3'd0, 0, "mode_level_busy");
    comp_i = 1'b1;
    applyStimulus(0, 0, 3'd0, 0, "mode_level_comp");
    comp_i = 1'b0;
    applyStimulus(0, 0, 3'd0, 0, "mode_level_idle");

    // Reset mid-operation: busy with two queued edges
    mode_i = 1'b1;
    applyStimulus(0, 0, 3'd0, 0, "rst_mode");
    zCnt = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3};
    for (int k = 1; k < 13; k++) begin
      irq_i = (((k - 1) % 4) < 2);
      applyStimulus((k >= 4), 0, 3'(zCnt[k]), 0, $sformatf("rst_edge_%0d", k));
    end
    irq_i   = 1'b0;
    ready_i = 1'b1;
    applyStimulus(0, 1, 3'd2, 0, "rst_busy_cnt2");
    ready_i = 1'b0;
    preset  = 1'b1;
    applyStimulus(0, 0, 3'd0, 0, "rst_mid_op");
    preset = 1'b0;
    applyStimulus(0, 0, 3'd0, 0, "rst_release0");
    applyStimulus(0, 0, 3'd0, 0, "rst_release1");
    applyStimulus(0, 0, 3'd0, 0, "rst_release2");
    applyStimulus(0, 0, 3'd0, 0, "rst_release3");

    // Let the monitor consume everything, with a bounded wait
    for (int i = 0; i < 10; i++) begin
      if (expQ.size() == 0) break;
      @(posedge pclk);
    end
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain expectations left %0d want 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
